// File: rtl/flit_sender_pkg.sv
// Shared NoC definitions for the flit sender: default flit width and
// the sender state encodings.
package flit_sender_pkg;

  localparam int FLIT_WIDTH_DEF = 36;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    SEND  = 2'd2,
    SPENT = 2'd3
  } send_state_e;

endpackage

// File: rtl/flit_sender_buffer.sv
// Two-entry FIFO holding flits ahead of the credit-gated sender.
// ready is a registered not-full so upstream sees a clean flop output.
module flit_buffer
  import flit_sender_pkg::*;
#(
  parameter int WIDTH = FLIT_WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             ready
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       cnt;
  logic [1:0]       cnt_next;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == 2'd2);
  assign empty    = (cnt == 2'd0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    cnt_next = cnt;
    if (do_push && !do_pop) begin
      cnt_next = cnt + 2'd1;
    end else if (do_pop && !do_push) begin
      cnt_next = cnt - 2'd1;
    end
  end

  // Storage, pointers, occupancy and the registered ready flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
      ready  <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt   <= cnt_next;
      ready <= (cnt_next != 2'd2);
    end
  end

endmodule

// File: rtl/flit_sender.sv
// Credit-gated flit sender: releases at most one buffered flit per
// simulation time step while credit is available, and counts time steps
// lost to credit starvation.
module flit_sender
  import flit_sender_pkg::*;
#(
  parameter int FLIT_WIDTH   = FLIT_WIDTH_DEF,
  parameter int CREDIT_WIDTH = 4,
  parameter int STALL_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    sim_time_tick,
  input  logic [FLIT_WIDTH-1:0]   flit_in,
  input  logic                    flit_in_valid,
  output logic                    flit_in_ready,
  input  logic [CREDIT_WIDTH-1:0] credit_count,
  output logic                    credit_decrement,
  output logic [FLIT_WIDTH-1:0]   flit_out,
  output logic                    flit_out_valid,
  input  logic                    flit_out_ack,
  output logic [STALL_WIDTH-1:0]  stall_count
);

  send_state_e             state;
  send_state_e             state_d;
  logic                    tick_pending;
  logic                    tick_pending_d;
  logic [FLIT_WIDTH-1:0]   flit_out_d;
  logic                    flit_out_valid_d;
  logic                    credit_decrement_d;
  logic [STALL_WIDTH-1:0]  stall_count_d;
  logic                    tick_en;
  logic                    buf_push;
  logic                    buf_pop;
  logic                    buf_full;
  logic                    buf_empty;
  logic [FLIT_WIDTH-1:0]   buf_head;

  assign tick_en  = sim_time_tick && enable;
  assign buf_push = flit_in_valid && flit_in_ready && !buf_full;

  flit_buffer #(
    .WIDTH (FLIT_WIDTH)
  ) u_buf (
    .clock     (clock),
    .reset     (reset),
    .push      (buf_push),
    .push_data (flit_in),
    .pop       (buf_pop),
    .pop_data  (buf_head),
    .full      (buf_full),
    .empty     (buf_empty),
    .ready     (flit_in_ready)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Registered outputs, pending-tick flag and starvation counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flit_out         <= '0;
      flit_out_valid   <= 1'b0;
      credit_decrement <= 1'b0;
      tick_pending     <= 1'b0;
      stall_count      <= '0;
    end else begin
      flit_out         <= flit_out_d;
      flit_out_valid   <= flit_out_valid_d;
      credit_decrement <= credit_decrement_d;
      tick_pending     <= tick_pending_d;
      stall_count      <= stall_count_d;
    end
  end

  // Next-state and next-output decisions.
  always_comb begin
    state_d            = state;
    flit_out_d         = flit_out;
    flit_out_valid_d   = flit_out_valid;
    credit_decrement_d = 1'b0;
    tick_pending_d     = tick_pending;
    stall_count_d      = stall_count;
    buf_pop            = 1'b0;
    case (state)
      IDLE: begin
        if (tick_en) state_d = READY;
      end
      READY: begin
        if (!buf_empty && (credit_count != '0) && enable) begin
          buf_pop            = 1'b1;
          flit_out_d         = buf_head;
          flit_out_valid_d   = 1'b1;
          credit_decrement_d = 1'b1;
          state_d            = SEND;
        end else if (tick_en && !buf_empty && (credit_count == '0)
                     && (stall_count != '1)) begin
          stall_count_d = stall_count + STALL_WIDTH'(1);
        end
      end
      SEND: begin
        if (flit_out_ack) begin
          flit_out_valid_d = 1'b0;
          tick_pending_d   = 1'b0;
          // A tick landing on the ack cycle counts as pending.
          state_d = (tick_pending || tick_en) ? READY : SPENT;
        end else if (tick_en) begin
          tick_pending_d = 1'b1;
        end
      end
      SPENT: begin
        if (tick_en) state_d = READY;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_flit_sender.sv
// Directed bench for flit_sender; stall counter narrowed to 3 bits so
// saturation is reachable by ticking.
module tb_flit_sender;
  import flit_sender_pkg::*;

  localparam int FW = 36;
  localparam int CW = 4;
  localparam int SW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          sim_time_tick = 1'b0;
  logic [FW-1:0] flit_in = '0;
  logic          flit_in_valid = 1'b0;
  logic          flit_in_ready;
  logic [CW-1:0] credit_count = '0;
  logic          credit_decrement;
  logic [FW-1:0] flit_out;
  logic          flit_out_valid;
  logic          flit_out_ack = 1'b0;
  logic [SW-1:0] stall_count;

  int errors = 0;
  int checks = 0;
  int dec_total = 0;
  int dec_double = 0;
  int dec_mark;
  logic prev_dec = 1'b0;

  flit_sender #(
    .FLIT_WIDTH   (FW),
    .CREDIT_WIDTH (CW),
    .STALL_WIDTH  (SW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .sim_time_tick    (sim_time_tick),
    .flit_in          (flit_in),
    .flit_in_valid    (flit_in_valid),
    .flit_in_ready    (flit_in_ready),
    .credit_count     (credit_count),
    .credit_decrement (credit_decrement),
    .flit_out         (flit_out),
    .flit_out_valid   (flit_out_valid),
    .flit_out_ack     (flit_out_ack),
    .stall_count      (stall_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (credit_decrement) dec_total++;
    if (credit_decrement && prev_dec) dec_double++;
    prev_dec = credit_decrement;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic tick_pulse();
    sim_time_tick = 1'b1;
    step();
    sim_time_tick = 1'b0;
  endtask

  task automatic push(input logic [FW-1:0] d);
    flit_in       = d;
    flit_in_valid = 1'b1;
    step();
    flit_in_valid = 1'b0;
  endtask

  task automatic ack_pulse();
    flit_out_ack = 1'b1;
    step();
    flit_out_ack = 1'b0;
  endtask

  initial begin
    // Reset values
    step(); step();
    check("rst_ready", flit_in_ready, 0);
    check("rst_valid", flit_out_valid, 0);
    check("rst_flit", flit_out, 0);
    check("rst_dec", credit_decrement, 0);
    check("rst_stall", stall_count, 0);
    check("rst_state", dut.state, IDLE);
    reset = 1'b0;
    step();
    check("ready_after_rst", flit_in_ready, 1);

    // 1: single flit
    credit_count = 4'd5;
    push(36'hA1);
    dec_mark = dec_total;
    tick_pulse();
    check("t1_no_valid_at_tick", flit_out_valid, 0);
    step();
    check("t1_flit", flit_out, 36'hA1);
    check("t1_valid", flit_out_valid, 1);
    check("t1_dec", credit_decrement, 1);
    step();
    check("t1_dec_one_cycle", credit_decrement, 0);
    check("t1_valid_hold", flit_out_valid, 1);
    ack_pulse();
    check("t1_valid_drop", flit_out_valid, 0);
    check("t1_state_spent", dut.state, SPENT);
    check("t1_dec_count", dec_total - dec_mark, 1);

    // 2: two flits, one per tick, third push waits for pop
    dec_mark = dec_total;
    push(36'hB1);
    push(36'hB2);
    check("t2_full_ready", flit_in_ready, 0);
    flit_in       = 36'hB3;
    flit_in_valid = 1'b1;
    tick_pulse();
    check("t2_still_full", flit_in_ready, 0);
    step();
    check("t2_first_b1", flit_out, 36'hB1);
    check("t2_ready_after_pop", flit_in_ready, 1);
    step();
    flit_in_valid = 1'b0;
    check("t2_b3_accepted", flit_in_ready, 0);
    ack_pulse();
    check("t2_spent_after_b1", dut.state, SPENT);
    step();
    check("t2_no_send_wo_tick", flit_out_valid, 0);
    tick_pulse();
    step();
    check("t2_second_b2", flit_out, 36'hB2);
    check("t2_valid_b2", flit_out_valid, 1);
    ack_pulse();
    check("t2_dec_count", dec_total - dec_mark, 2);
    tick_pulse();
    step();
    check("t2_third_b3", flit_out, 36'hB3);
    ack_pulse();

    // 3: credit starvation
    credit_count = 4'd0;
    dec_mark = dec_total;
    push(36'hC1);
    tick_pulse();
    check("t3_no_stall_on_open", stall_count, 0);
    for (int i = 0; i < 3; i++) begin
      tick_pulse();
      step();
    end
    check("t3_stall3", stall_count, 3);
    check("t3_no_valid", flit_out_valid, 0);
    check("t3_no_dec", dec_total - dec_mark, 0);
    credit_count = 4'd1;
    tick_pulse();
    check("t3_c1_sent", flit_out, 36'hC1);
    check("t3_c1_valid", flit_out_valid, 1);
    check("t3_stall_kept", stall_count, 3);
    ack_pulse();
    check("t3_spent", dut.state, SPENT);

    // 4: long ack with a tick during SEND
    credit_count = 4'd5;
    push(36'hD1);
    push(36'hD2);
    tick_pulse();
    step();
    check("t4_d1", flit_out, 36'hD1);
    step();
    tick_pulse();
    step();
    step();
    check("t4_hold_flit", flit_out, 36'hD1);
    check("t4_hold_valid", flit_out_valid, 1);
    check("t4_hold_no_dec", credit_decrement, 0);
    ack_pulse();
    check("t4_ack_drop", flit_out_valid, 0);
    check("t4_ready_from_pending", dut.state, READY);
    step();
    check("t4_d2", flit_out, 36'hD2);
    check("t4_d2_valid", flit_out_valid, 1);
    check("t4_d2_dec", credit_decrement, 1);
    ack_pulse();
    check("t4_spent", dut.state, SPENT);

    // 5: enable gating
    enable = 1'b0;
    credit_count = 4'd3;
    dec_mark = dec_total;
    push(36'hE1);
    push(36'hE2);
    tick_pulse();
    step();
    check("t5_no_send", flit_out_valid, 0);
    check("t5_no_dec", dec_total - dec_mark, 0);
    check("t5_tick_ignored", dut.state, SPENT);
    enable = 1'b1;
    tick_pulse();
    step();
    check("t5_e1", flit_out, 36'hE1);
    check("t5_e1_valid", flit_out_valid, 1);

    // 6: reset mid-SEND, then stall saturation
    #2;
    reset = 1'b1;
    #1;
    check("t6_valid0", flit_out_valid, 0);
    check("t6_flit0", flit_out, 0);
    check("t6_dec0", credit_decrement, 0);
    check("t6_ready0", flit_in_ready, 0);
    check("t6_stall0", stall_count, 0);
    check("t6_idle", dut.state, IDLE);
    step();
    reset = 1'b0;
    step();
    credit_count = 4'd5;
    tick_pulse();
    step();
    check("t6_buffer_flushed", flit_out_valid, 0);
    check("t6_ready_state", dut.state, READY);
    credit_count = 4'd0;
    push(36'hF1);
    for (int i = 0; i < 6; i++) begin
      tick_pulse();
      step();
    end
    check("t6_stall6", stall_count, 6);
    for (int i = 0; i < 3; i++) begin
      tick_pulse();
      step();
    end
    check("t6_stall_sat", stall_count, 7);
    check("no_back_to_back_dec", dec_double, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
